// File: rtl/mem_decoder.sv
// Registered DTACK generator for the 68000 bus: per-region wait states for RAM/ROM,
// synchronized pass-through of the DUART's own DTACK, release on select negation.
module mem_decoder #(
    parameter int RAM_WAIT = 0,
    parameter int ROM_WAIT = 2,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ram_evn_cs,
    input  logic ram_odd_cs,
    input  logic rom_evn_cs,
    input  logic rom_odd_cs,
    input  logic duart_cs,
    input  logic duart_dtack,
    output logic dtack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DUART  = 2'd2,
        ASSERT = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] RAM_N = WAIT_W'(RAM_WAIT);
    localparam logic [WAIT_W-1:0] ROM_N = WAIT_W'(ROM_WAIT);

    state_t            state_r;
    state_t            state_s;
    logic [WAIT_W-1:0] cnt_r;
    logic [WAIT_W-1:0] cnt_s;
    logic              sync1_r;
    logic              dsync_r;
    logic              dtack_r;
    logic              rom_sel_s;
    logic              ram_sel_s;
    logic              duart_sel_s;
    logic              any_sel_s;

    // Byte and word accesses are treated alike: either half of a pair selects the region.
    assign rom_sel_s   = ~rom_evn_cs | ~rom_odd_cs;
    assign ram_sel_s   = ~ram_evn_cs | ~ram_odd_cs;
    assign duart_sel_s = ~duart_cs;
    assign any_sel_s   = rom_sel_s | ram_sel_s | duart_sel_s;

    // Next-state and wait-counter logic; region is latched only when leaving IDLE.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (rom_sel_s) begin
                    state_s = COUNT;
                    cnt_s   = ROM_N;
                end else if (ram_sel_s) begin
                    state_s = COUNT;
                    cnt_s   = RAM_N;
                end else if (duart_sel_s) begin
                    state_s = DUART;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (!any_sel_s) begin
                    state_s = IDLE;
                end else if (cnt_r == {WAIT_W{1'b0}}) begin
                    state_s = ASSERT;
                end else begin
                    cnt_s = cnt_r - WAIT_W'(1);
                end
            end
            DUART: begin
                if (!any_sel_s) begin
                    state_s = IDLE;
                end else if (!dsync_r) begin
                    state_s = ASSERT;
                end else begin
                    state_s = DUART;
                end
            end
            ASSERT: begin
                if (!any_sel_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ASSERT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {WAIT_W{1'b0}};
            end
        endcase
    end

    // State, counter and output register; dtack is derived from the next state so it
    // changes on the same edge as the transition into or out of ASSERT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {WAIT_W{1'b0}};
            dtack_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            dtack_r <= (state_s == ASSERT) ? 1'b0 : 1'b1;
        end
    end

    // Two-flop synchronizer for the DUART's asynchronous DTACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            dsync_r <= 1'b1;
        end else begin
            sync1_r <= duart_dtack;
            dsync_r <= sync1_r;
        end
    end

    assign dtack = dtack_r;

endmodule

// File: tb/tb_mem_decoder.sv
// Self-checking bench for mem_decoder: vector table, directed corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_mem_decoder;

    localparam int RAM_W = 0;
    localparam int ROM_W = 2;
    localparam logic [4:0] ALL_HIGH = 5'b11111;

    logic clk = 1'b0;
    logic reset;
    logic ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs;
    logic duart_dtack;
    logic dtack;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_decoder #(.RAM_WAIT(RAM_W), .ROM_WAIT(ROM_W), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset),
        .ram_evn_cs(ram_evn_cs), .ram_odd_cs(ram_odd_cs),
        .rom_evn_cs(rom_evn_cs), .rom_odd_cs(rom_odd_cs),
        .duart_cs(duart_cs), .duart_dtack(duart_dtack),
        .dtack(dtack)
    );

    // cs bit order: {ram_evn, ram_odd, rom_evn, rom_odd, duart}, all active-low
    typedef struct {
        logic [4:0] cs;
        logic       ddt;
        int         hold;
        int         first_low;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // reference model state: an access is a start edge plus a deadline rule
    bit m_active;
    bit m_asserted;
    int m_start;
    int m_wait;
    int edge_n;
    logic d1, d2;

    task automatic set_cs(input logic [4:0] c);
        ram_evn_cs = c[4];
        ram_odd_cs = c[3];
        rom_evn_cs = c[2];
        rom_odd_cs = c[1];
        duart_cs   = c[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic exp);
        tests++;
        if (dtack !== exp) begin
            failed++;
            $display("FAIL %s: dtack=%b expected %b at %0t", nm, dtack, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [4:0] cs, input logic ddt, input int hold,
                           input int first_low, input string name);
        vec_t v;
        v.cs = cs; v.ddt = ddt; v.hold = hold; v.first_low = first_low; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_asserted = 1'b0; m_start = 0; m_wait = 0;
        edge_n = 0; d1 = 1'b1; d2 = 1'b1;
    endtask

    task automatic step_rand();
        logic [4:0] c;
        logic seen;
        bit rom, ram, any;
        @(posedge clk);
        c    = {ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs};
        rom  = !c[2] || !c[1];
        ram  = !c[4] || !c[3];
        any  = (c != ALL_HIGH);
        seen = d2;
        d2   = d1;
        d1   = duart_dtack;
        if (!m_active) begin
            if (any) begin
                m_active   = 1'b1;
                m_asserted = 1'b0;
                m_start    = edge_n;
                m_wait     = rom ? ROM_W : (ram ? RAM_W : -1);
            end
        end else if (!any) begin
            m_active   = 1'b0;
            m_asserted = 1'b0;
        end else if (!m_asserted) begin
            if (m_wait >= 0) m_asserted = (edge_n >= m_start + 1 + m_wait);
            else             m_asserted = (seen == 1'b0);
        end
        edge_n++;
        #1;
        check("rand", m_asserted ? 1'b0 : 1'b1);
    endtask

    initial begin
        // reset held with a ROM select active, then released idle
        reset = 1'b0;
        duart_dtack = 1'b1;
        set_cs(5'b11011);
        repeat (3) tick();
        check("reset_hold", 1'b1);
        set_cs(ALL_HIGH);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_release", 1'b1);
        end

        add_vec(5'b11011, 1'b1, 5, 3,  "rom_even");
        add_vec(5'b11101, 1'b1, 5, 3,  "rom_odd");
        add_vec(5'b00111, 1'b1, 3, 1,  "ram_word");
        add_vec(5'b01111, 1'b1, 3, 1,  "ram_even");
        add_vec(5'b00001, 1'b0, 5, 3,  "rom_priority");
        add_vec(5'b01110, 1'b0, 3, 1,  "ram_over_duart");
        add_vec(5'b11101, 1'b1, 1, 99, "abort_rom_1");
        add_vec(5'b11101, 1'b1, 3, 99, "abort_rom_3");
        add_vec(5'b11110, 1'b1, 10, 99, "duart_silent");
        add_vec(5'b11110, 1'b0, 4, 1,  "duart_ready");

        foreach (vecs[i]) begin
            duart_dtack = vecs[i].ddt;
            set_cs(ALL_HIGH);
            tick();
            tick();
            check({vecs[i].name, "_idle"}, 1'b1);
            set_cs(vecs[i].cs);
            for (int j = 0; j < vecs[i].hold; j++) begin
                tick();
                check(vecs[i].name, (j >= vecs[i].first_low) ? 1'b0 : 1'b1);
            end
            set_cs(ALL_HIGH);
            tick();
            check({vecs[i].name, "_release"}, 1'b1);
        end

        // widening a ROM byte access to a word must not restart the wait count
        duart_dtack = 1'b1;
        tick();
        set_cs(5'b11011);
        tick(); check("widen_k", 1'b1);
        set_cs(5'b11001);
        tick(); check("widen_k1", 1'b1);
        tick(); check("widen_k2", 1'b1);
        tick(); check("widen_k3", 1'b0);
        set_cs(ALL_HIGH);
        tick(); check("widen_release", 1'b1);

        // DUART answers late: three edges after its DTACK falls
        tick();
        set_cs(5'b11110);
        for (int i = 0; i < 4; i++) begin
            tick(); check("duart_wait", 1'b1);
        end
        duart_dtack = 1'b0;
        tick(); check("duart_sync1", 1'b1);
        tick(); check("duart_sync2", 1'b1);
        tick(); check("duart_ack", 1'b0);
        set_cs(ALL_HIGH);
        duart_dtack = 1'b1;
        tick(); check("duart_release", 1'b1);

        // asynchronous reset while DTACK is asserted
        tick();
        set_cs(5'b00111);
        tick(); check("pre_reset_k", 1'b1);
        tick(); check("pre_reset_assert", 1'b0);
        #2 reset = 1'b0;
        #1 check("async_reset", 1'b1);
        set_cs(ALL_HIGH);
        @(negedge clk);
        reset = 1'b1;
        tick(); check("post_reset_idle", 1'b1);
        set_cs(5'b00111);
        tick(); check("post_reset_k", 1'b1);
        tick(); check("post_reset_assert", 1'b0);
        set_cs(ALL_HIGH);
        tick(); check("post_reset_release", 1'b1);

        // randomized traffic against the reference model
        @(negedge clk);
        reset = 1'b0;
        set_cs(ALL_HIGH);
        duart_dtack = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 300; n++) begin
            logic [4:0] c;
            int hold;
            int gap;
            c    = 5'($urandom_range(0, 30));
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 3) == 0) duart_dtack = ~duart_dtack;
                if ($urandom_range(0, 5) == 0) c = c & 5'($urandom);
                set_cs(c);
                step_rand();
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) duart_dtack = ~duart_dtack;
                set_cs(ALL_HIGH);
                step_rand();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
